// File: rtl/uart_rx_fsm.sv
// UART receiver: synchronizes rx, finds the start edge, samples each bit at its centre
// and hands complete words downstream on a valid/ready handshake with error pulses.
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] dataout,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_ONE  = {{(BIT_W-1){1'b0}}, 1'b1};
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_r, state_n;
  logic                 rx_meta_r, rx_sync_r, rx_prev_r;
  logic [CNT_W-1:0]     cnt_r, cnt_n;
  logic [BIT_W-1:0]     bit_idx_r, bit_idx_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic [DATA_BITS-1:0] dataout_r, dataout_n;
  logic                 valid_r, valid_n;
  logic                 frame_err_r, frame_err_n;
  logic                 overrun_r, overrun_n;
  logic                 busy_r;

  // Position in the word where the data bit with index idx is stored.
  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx);
    if (MSB_FIRST) begin
      bit_pos = IDX_TOP - idx;
    end else begin
      bit_pos = idx;
    end
  endfunction

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      bit_idx_r   <= BIT_ZERO;
      shift_r     <= {DATA_BITS{1'b0}};
      dataout_r   <= {DATA_BITS{1'b0}};
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      bit_idx_r   <= bit_idx_n;
      shift_r     <= shift_n;
      dataout_r   <= dataout_n;
      valid_r     <= valid_n;
      frame_err_r <= frame_err_n;
      overrun_r   <= overrun_n;
      busy_r      <= (state_n != IDLE);
    end
  end

  // Next-state, bit timing and delivery decisions.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    bit_idx_n   = bit_idx_r;
    shift_n     = shift_r;
    dataout_n   = dataout_r;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
    if (valid_r && ready) begin
      valid_n = 1'b0;
    end else begin
      valid_n = valid_r;
    end

    case (state_r)
      IDLE: begin
        if (rx_prev_r && !rx_sync_r) begin
          state_n = START;
          cnt_n   = CNT_ZERO;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        // A start bit that is high again at its centre was only a glitch.
        if (cnt_r == CNT_HALF) begin
          cnt_n     = CNT_ZERO;
          bit_idx_n = BIT_ZERO;
          if (!rx_sync_r) begin
            state_n = DATA;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          shift_n[bit_pos(bit_idx_r[IDX_W-1:0])] = rx_sync_r;
          cnt_n     = CNT_ZERO;
          bit_idx_n = bit_idx_r + BIT_ONE;
          if (bit_idx_r == BIT_LAST) begin
            state_n = STOP;
          end else begin
            state_n = DATA;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_n   = CNT_ZERO;
          state_n = IDLE;
          if (rx_sync_r) begin
            // A held word that is not being accepted wins over the new one.
            if (!valid_r || ready) begin
              dataout_n = shift_r;
              valid_n   = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
          end else begin
            frame_err_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = CNT_ZERO;
      end
    endcase
  end

  assign dataout   = dataout_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: serial frames are driven bit by bit, expected words
// go into a scoreboard queue and are matched against words accepted on the handshake.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] dataout;
  logic       valid, frame_err, overrun, busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         vcyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_rx_fsm #(.CLKS_PER_BIT(16), .DATA_BITS(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .rx(rx), .ready(ready), .dataout(dataout),
    .valid(valid), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Event collection on the inactive edge; the tests do the comparing.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid && ready) got_q.push_back(dataout);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (valid) vcyc++;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (dataout !== 8'h00) begin n_bad++; $display("FAIL rst_dataout: got %h need 00", dataout); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b need 0", valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_frame_err: got %b need 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b need 0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b need 0", busy); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || valid !== 1'b0) begin n_bad++; $display("FAIL idle_after_rst: busy %b valid %b need 0 0", busy, valid); end
  endtask

  task automatic test_frame();
    int fe0, v0;
    logic [7:0] e, g;
    fe0 = fe_cnt; v0 = vcyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL a5_count: got %0d words need 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL a5_word: got %h need %h", g, e); end
    end
    n_cmp++; if (vcyc - v0 != 1) begin n_bad++; $display("FAIL a5_valid_len: got %0d cycles need 1", vcyc - v0); end
    n_cmp++; if (fe_cnt != fe0) begin n_bad++; $display("FAIL a5_frame_err: got %0d pulses need 0", fe_cnt - fe0); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_hi: got %b need 1", busy); end
    repeat (16) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_lo: got %b need 0", busy); end
    n_cmp++; if (got_q.size() != 0 || valid !== 1'b0) begin n_bad++; $display("FAIL glitch_valid: got %0d words need 0", got_q.size()); end
    n_cmp++; if (fe_cnt != fe0) begin n_bad++; $display("FAIL glitch_frame_err: got %0d pulses need 0", fe_cnt - fe0); end
    got_q.delete();
  endtask

  task automatic test_frame_err();
    int fe0;
    logic [7:0] e, g;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    n_cmp++; if (fe_cnt - fe0 != 1) begin n_bad++; $display("FAIL fe_pulse: got %0d pulses need 1", fe_cnt - fe0); end
    n_cmp++; if (got_q.size() != 0 || valid !== 1'b0) begin n_bad++; $display("FAIL fe_discard: got %0d words valid %b need 0 0", got_q.size(), valid); end
    got_q.delete();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL fe_next_count: got %0d words need 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL fe_next_word: got %h need %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overrun();
    int ov0;
    logic [7:0] e;
    ov0 = ov_cnt;
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b need 1", valid); end
    n_cmp++; if (dataout !== e) begin n_bad++; $display("FAIL ovr_dataout: got %h need %h", dataout, e); end
    n_cmp++; if (ov_cnt - ov0 != 1) begin n_bad++; $display("FAIL ovr_pulse: got %0d pulses need 1", ov_cnt - ov0); end
    #1 ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ovr_release: got valid %b need 0", valid); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] e, g;
    ready = 1'b0;
    send_frame(8'h77, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++; if (valid !== 1'b1 || dataout !== 8'h77) begin n_bad++; $display("FAIL held_word: got valid %b data %h need 1 77", valid, dataout); end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b need 1", busy); end
    #1 reset = 1'b1;
    rx = 1'b1;
    #1;
    n_cmp++; if (dataout !== 8'h00 || valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_data: got data %h valid %b need 00 0", dataout, valid); end
    n_cmp++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags: got busy %b fe %b ov %b need 0 0 0", busy, frame_err, overrun); end
    @(negedge clk);
    reset = 1'b0;
    ready = 1'b1;
    got_q.delete();
    repeat (32) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL post_rst_count: got %0d words need 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL post_rst_word: got %h need %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    int fe0, ov0;
    logic [7:0] e, g;
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_frame(d, 1'b1);
    end
    repeat (20) @(negedge clk);
    n_cmp++; if (got_q.size() != 6) begin n_bad++; $display("FAIL b2b_count: got %0d words need 6", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_word: got %h need %h", g, e); end
    end
    n_cmp++; if (fe_cnt != fe0 || ov_cnt != ov0) begin n_bad++; $display("FAIL b2b_errors: got fe %0d ov %0d need 0 0", fe_cnt - fe0, ov_cnt - ov0); end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
